sram_1rw_arbiter: RTL
=====================

Name: sram_1rw_arbiter

Overview:
Controller for a single-port 1RW SRAM macro with 1-cycle read latency, whose read data is valid only on the cycle after a read. It runs a post-reset zero-fill of every entry. It then shares the port between one read requester and one write requester: reads have priority, and a bounded-starvation counter guarantees write progress. Each read response is a single-cycle valid, and the data is held stable afterwards until the next read.

Parameters:
DATA_W, 8, data width of the macro.
ADDR_W, 1, address width; DEPTH = 2**ADDR_W entries.
STARVE_MAX, 3, consecutive cycles a valid write may lose to reads before it is forced through (min 1).

Ports:
clock  input  1  sole clock.
reset  input  1  synchronous, active-high.
init_done  output  1  high once zero-fill is complete.
r_req_valid  input  1  read request.
r_req_ready  output  1  read accepted when valid && ready.
r_req_addr  input  ADDR_W  read address.
r_resp_valid  output  1  one-cycle pulse, the cycle after a read is accepted.
r_resp_data  output  DATA_W  read data; held after the pulse.
w_req_valid  input  1  write request.
w_req_ready  output  1  write accepted when valid && ready.
w_req_addr  input  ADDR_W  write address.
w_req_data  input  DATA_W  write data.
sram_en  output  1  macro enable.
sram_wmode  output  1  1 = write, 0 = read.
sram_addr  output  ADDR_W  macro address.
sram_wdata  output  DATA_W  macro write data.
sram_rdata  input  DATA_W  macro read data, valid the cycle after a read enable.

Behaviour:
- Reset values:
  - state = INIT, init_cnt = 0, starve_cnt = 0.
  - init_done = 0, r_resp_valid = 0, held data register = 0.
  - Both readies 0.
- States: INIT, IDLE. The encoding is local to the module.
- INIT:
  - Each cycle drives sram_en = 1, sram_wmode = 1, sram_addr = init_cnt, sram_wdata = 0.
  - init_cnt increments by 1.
  - After the write to DEPTH-1 the state moves to IDLE. The fill takes exactly DEPTH cycles.
  - init_done rises on the first IDLE cycle.
  - r_req_ready = w_req_ready = 0 throughout INIT; requests are ignored, not queued.
- IDLE arbitration (combinational; force = (starve_cnt == STARVE_MAX)):
  - r_req_ready = !(w_req_valid && force).
  - w_req_ready = !r_req_valid || force.
  - Read fire: sram_en = 1, wmode = 0, addr = r_req_addr.
  - Write fire: sram_en = 1, wmode = 1, addr = w_req_addr, wdata = w_req_data.
  - Neither fires: sram_en = 0. The sram_addr and sram_wdata values are don't-care.
  - At most one fire per cycle.
- Starvation counter:
  - Increments when w_req_valid && !w_req_ready (saturating at STARVE_MAX).
  - Clears on write fire or when w_req_valid = 0.
- Read response:
  - r_resp_valid is registered: it equals the read fire of the previous cycle.
  - While r_resp_valid = 1, r_resp_data = sram_rdata (pass-through) and the held register loads sram_rdata.
  - Otherwise r_resp_data = held register. It never shows macro garbage.
- Ordering:
  - Read-vs-write ordering to the same address follows grant order.
  - A read granted over a same-cycle write to the same address returns the old value.
  - A read in the cycle after a write to the same address returns the new value.
  - No bypass.
- Back-to-back reads give one response per cycle, with latency 1.
- Reset mid-operation:
  - State returns to INIT on the next edge and the fill restarts from address 0.
  - A response pending from the reset cycle is dropped: r_resp_valid = 0 on the cycle after reset.
  - Held data is cleared to 0.

Decomposition:
- Shared package holds:
  - the state enum (INIT, IDLE);
  - a helper giving DEPTH from ADDR_W;
  - the read-request, write-request and response typedefs parameterised by DATA_W/ADDR_W, for reuse by other controllers driving array macros.
- One natural sub-module: sram_starve_counter (saturating counter with clear, compare-to-max output). Everything else stays in the top.

Test Plan:
- Reset, no requests -> sram_en = 1, wmode = 1, wdata = 0 at addr 0 then 1; init_done = 1 on cycle 3; readies 0 for cycles 1-2.
- Write addr 1 data 0xA5 after init, then read addr 1 next cycle -> r_resp_valid pulse one cycle after the read fire, r_resp_data = 0xA5, still 0xA5 three idle cycles later.
- Read addr 0 with no prior write -> r_resp_data = 0x00, proving the zero-fill.
- r_req_valid held high continuously with w_req_valid = 1 (addr 0, data 0x3C), STARVE_MAX = 3 -> reads fire 3 cycles, the write fires on cycle 4 with r_req_ready = 0, reads resume cycle 5; a subsequent read of addr 0 returns 0x3C.
- Same-cycle read and write to addr 1 (old 0xA5, new 0x11), starve_cnt = 0 -> read returns 0xA5; a read issued after the write fires returns 0x11.
- Assert reset in the cycle a read fires -> no r_resp_valid next cycle; full DEPTH-cycle zero-fill repeats; a read of a previously written address returns 0x00.

Source files
------------

// File: rtl/sram_1rw_arbiter_pkg.sv
// Shared types and helpers for controllers that sit in front of single-port array macros.
package sram_1rw_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } arb_state_e;

    localparam int unsigned PKG_DATA_W = 8;
    localparam int unsigned PKG_ADDR_W = 1;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] data;
    } wr_req_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] data;
    } rd_resp_t;

endpackage

// File: rtl/sram_1rw_arbiter_starve.sv
// Saturating count of consecutive cycles a pending write has lost arbitration.
module sram_starve_counter #(
    parameter int unsigned MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, increment saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sram_1rw_arbiter.sv
// 1RW SRAM port controller: zero-fill after reset, then read-priority arbitration
// with a starvation bound on writes and a held read-response register.
module sram_1rw_arbiter
    import sram_1rw_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    localparam int unsigned DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
    logic              r_resp_valid_q, r_resp_valid_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic              r_fire, w_fire;
    logic              force_w;

    // Fill sequencing and port arbitration.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        r_req_ready = 1'b0;
        w_req_ready = 1'b0;
        r_fire      = 1'b0;
        w_fire      = 1'b0;
        sram_en     = 1'b0;
        sram_wmode  = 1'b0;
        sram_addr   = {ADDR_W{1'b0}};
        sram_wdata  = {DATA_W{1'b0}};
        case (state_q)
            ST_INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = init_cnt_q;
                sram_wdata = {DATA_W{1'b0}};
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                r_req_ready = !(w_req_valid && force_w);
                w_req_ready = !r_req_valid || force_w;
                r_fire      = r_req_valid && r_req_ready;
                w_fire      = w_req_valid && w_req_ready && !r_fire;
                if (r_fire) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b0;
                    sram_addr  = r_req_addr;
                end else if (w_fire) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = w_req_addr;
                    sram_wdata = w_req_data;
                end else begin
                    sram_en = 1'b0;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    sram_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clock  (clock),
        .reset  (reset),
        .inc    ((state_q == ST_IDLE) && w_req_valid && !w_req_ready),
        .clr    (!w_req_valid || w_fire),
        .at_max (force_w)
    );

    // Response path: macro data passes through on the valid cycle and is captured for later.
    always_comb begin
        r_resp_valid_d = r_fire;
        init_done_d    = (state_d == ST_IDLE);
        if (r_resp_valid_q) begin
            held_d      = sram_rdata;
            r_resp_data = sram_rdata;
        end else begin
            held_d      = held_q;
            r_resp_data = held_q;
        end
    end

    // State, fill pointer and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_INIT;
            init_cnt_q     <= {ADDR_W{1'b0}};
            init_done_q    <= 1'b0;
            r_resp_valid_q <= 1'b0;
            held_q         <= {DATA_W{1'b0}};
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            init_done_q    <= init_done_d;
            r_resp_valid_q <= r_resp_valid_d;
            held_q         <= held_d;
        end
    end

    assign init_done    = init_done_q;
    assign r_resp_valid = r_resp_valid_q;

endmodule
